// File: rtl/segment_receiver.sv
// rtl/segment_receiver.sv - serial LED segment link receiver with BCD decode
module segment_receiver #(
  parameter int NUM_DIGITS = 11,
  parameter int CNT_W      = 8
) (
  input  logic                    i_clk,
  input  logic                    i_resetn,
  input  logic                    i_ledClk,
  input  logic                    i_data,
  input  logic                    i_lat,
  input  logic                    i_blank,
  output logic [NUM_DIGITS*8-1:0] o_segData,
  output logic [NUM_DIGITS*4-1:0] o_bcdData,
  output logic [NUM_DIGITS-1:0]   o_digitError,
  output logic                    o_frameError,
  output logic                    o_valid,
  output logic                    o_blanked
);

  localparam int NBITS = NUM_DIGITS * 8;
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(NBITS);

  // Synchroniser stages, third delayed stage and registered edge pulses
  logic r_clk_s1, r_clk_s2, r_clk_d;
  logic r_data_s1, r_data_s2, r_data_d;
  logic r_lat_s1, r_lat_s2, r_lat_d;
  logic r_blank_s1, r_blank_s2;
  logic r_clk_rise, r_lat_rise;

  // Receive state and registered outputs
  logic [NBITS-1:0]        r_sr;
  logic [CNT_W-1:0]        r_cnt;
  logic [NBITS-1:0]        r_seg;
  logic [NUM_DIGITS*4-1:0] r_bcd;
  logic [NUM_DIGITS-1:0]   r_derr;
  logic                    r_ferr;
  logic                    r_valid;

  logic [NBITS-1:0]        w_sr_next;
  logic [CNT_W-1:0]        w_cnt_next;
  logic [NUM_DIGITS*4-1:0] w_bcd_next;
  logic [NUM_DIGITS-1:0]   w_derr_next;
  logic [4:0]              w_dec;

  // Returns {error, nibble} for a 7-segment pattern; dp is excluded by the caller
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'h3F:   return 5'h00;
      7'h06:   return 5'h01;
      7'h5B:   return 5'h02;
      7'h4F:   return 5'h03;
      7'h66:   return 5'h04;
      7'h6D:   return 5'h05;
      7'h7D:   return 5'h06;
      7'h07:   return 5'h07;
      7'h7F:   return 5'h08;
      7'h6F:   return 5'h09;
      7'h00:   return 5'h0F;
      default: return 5'h1E;
    endcase
  endfunction

  // Two-flop synchronisers plus a delayed stage; data gets the same depth so it lines up with the clock edge
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_clk_s1   <= 1'b0;
      r_clk_s2   <= 1'b0;
      r_clk_d    <= 1'b0;
      r_data_s1  <= 1'b0;
      r_data_s2  <= 1'b0;
      r_data_d   <= 1'b0;
      r_lat_s1   <= 1'b0;
      r_lat_s2   <= 1'b0;
      r_lat_d    <= 1'b0;
      r_blank_s1 <= 1'b0;
      r_blank_s2 <= 1'b0;
      r_clk_rise <= 1'b0;
      r_lat_rise <= 1'b0;
    end else begin
      r_clk_s1   <= i_ledClk;
      r_clk_s2   <= r_clk_s1;
      r_clk_d    <= r_clk_s2;
      r_data_s1  <= i_data;
      r_data_s2  <= r_data_s1;
      r_data_d   <= r_data_s2;
      r_lat_s1   <= i_lat;
      r_lat_s2   <= r_lat_s1;
      r_lat_d    <= r_lat_s2;
      r_blank_s1 <= i_blank;
      r_blank_s2 <= r_blank_s1;
      r_clk_rise <= r_clk_s2 & ~r_clk_d;
      r_lat_rise <= r_lat_s2 & ~r_lat_d;
    end
  end

  // Next shift-register and count values; a shift in the latch cycle is applied before the snapshot
  always_comb begin
    w_sr_next  = r_sr;
    w_cnt_next = r_cnt;
    if (r_clk_rise) begin
      w_sr_next  = {r_sr[NBITS-2:0], r_data_d};
      w_cnt_next = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    end
  end

  // Per-digit decode of the pattern that would be captured this cycle
  always_comb begin
    w_bcd_next  = '0;
    w_derr_next = '0;
    w_dec       = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_dec              = decode_seg(w_sr_next[8*k +: 7]);
      w_bcd_next[4*k +: 4] = w_dec[3:0];
      w_derr_next[k]     = w_dec[4];
    end
  end

  // Shift, count and capture the frame on the latch edge; outputs hold between latches
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_sr    <= '0;
      r_cnt   <= '0;
      r_seg   <= '0;
      r_bcd   <= '0;
      r_derr  <= '0;
      r_ferr  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_sr    <= w_sr_next;
      r_valid <= r_lat_rise;
      if (r_lat_rise) begin
        r_cnt  <= '0;
        r_seg  <= w_sr_next;
        r_bcd  <= w_bcd_next;
        r_derr <= w_derr_next;
        r_ferr <= (w_cnt_next != FRAME_LEN);
      end else begin
        r_cnt  <= w_cnt_next;
      end
    end
  end

  assign o_segData    = r_seg;
  assign o_bcdData    = r_bcd;
  assign o_digitError = r_derr;
  assign o_frameError = r_ferr;
  assign o_valid      = r_valid;
  assign o_blanked    = r_blank_s2;

endmodule
